// File: rtl/fir_pkg.sv
// Shared Q2.6 constants and helpers for the FIR chain.
package fir_pkg;

  localparam int unsigned WL = 8;
  localparam int unsigned WF = 6;
  localparam logic [WL-1:0] SAT_MAX = 8'h7F;
  localparam logic [WL-1:0] SAT_MIN = 8'h80;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Clip a wide signed value to the WL-bit two's complement range.
  function automatic logic [WL-1:0] saturate(input logic signed [31:0] v, output logic clipped);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic [WL-1:0]      r;
    hi = (32'sd1 <<< (WL - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (WL - 1));
    if (v > hi) begin
      r       = SAT_MAX;
      clipped = 1'b1;
    end else if (v < lo) begin
      r       = SAT_MIN;
      clipped = 1'b1;
    end else begin
      r       = v[WL-1:0];
      clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_fifo2.sv
// Two-entry valid/ready result buffer; a push while full is accepted only alongside a pop.
module fir_out_fifo2
  import fir_pkg::*;
#(
  parameter int unsigned W = WL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         push_ok_o,
  output logic         overrun_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop_w;

  assign pop_w     = pop_i && (cnt_q != 2'd0);
  assign push_ok_o = push_i && ((cnt_q != 2'd2) || pop_w);
  assign overrun_o = push_i && !push_ok_o;
  assign valid_o   = (cnt_q != 2'd0);
  assign data_o    = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_ok_o, pop_w})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Head keeps its last value when the buffer drains.
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fir_decim_accum.sv
// Accumulate-and-dump decimator behind the FIR stage, with scaled/saturated Q2.6 output.
// Define FIR_DECIM_ROUND_EN for round-half-up scaling instead of truncation.
module fir_decim_accum #(
  parameter int unsigned WL    = fir_pkg::WL,
  parameter int unsigned WF    = fir_pkg::WF,
  parameter int unsigned DECIM = 4,
  parameter int unsigned SHIFT = fir_pkg::clog2(DECIM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [WL-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [WL-1:0] out_data_o,
  output logic          overrun_o,
  output logic          sat_o,
  input  logic          flag_clr_i
);
  import fir_pkg::*;

  localparam int unsigned CW = clog2(DECIM);
  localparam int unsigned AW = WL + CW;

  if (WL != fir_pkg::WL || WF >= WL || DECIM < 2 || DECIM > 64 ||
      (1 << CW) != DECIM || SHIFT > CW) begin : g_bad_cfg
    $error("fir_decim_accum: unsupported parameter set");
  end

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW:0]   sum_w, res_w;
  logic signed [31:0]   res_ext_w;
  logic [WL-1:0]        sat_data_w;
  logic                 clipped_w;
  logic                 last_w, pop_w, push_ok_w, drop_w;
  logic                 sat_q, sat_d, overrun_q, overrun_d;

`ifdef FIR_DECIM_ROUND_EN
  localparam int                 RndInt = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
  localparam logic signed [AW:0] RndAdd = RndInt[AW:0];
`endif

  assign last_w = in_valid_i && (cnt_q == CW'(DECIM - 1));

  always_comb begin
    sum_w = $signed({acc_q[AW-1], acc_q}) + $signed({{(CW + 1){in_data_i[WL-1]}}, in_data_i});
`ifdef FIR_DECIM_ROUND_EN
    res_w = (sum_w + RndAdd) >>> SHIFT;
`else
    res_w = sum_w >>> SHIFT;
`endif
    res_ext_w  = {{(31 - AW){res_w[AW]}}, res_w};
    sat_data_w = saturate(res_ext_w, clipped_w);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid_i) begin
      if (last_w) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_w[AW-1:0];
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A new event in the same cycle as flag_clr keeps the flag set.
  assign sat_d     = (last_w && clipped_w) || (sat_q && !flag_clr_i);
  assign overrun_d = drop_w || (overrun_q && !flag_clr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign pop_w     = out_valid_o && out_ready_i;
  assign sat_o     = sat_q;
  assign overrun_o = overrun_q;

  fir_out_fifo2 #(
    .W (WL)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (last_w),
    .data_i    (sat_data_w),
    .pop_i     (pop_w),
    .push_ok_o (push_ok_w),
    .overrun_o (drop_w),
    .valid_o   (out_valid_o),
    .data_o    (out_data_o)
  );

  // Every produced result is either buffered or dropped, never both.
  a_push_xor_drop : assert property (@(posedge clk_i) disable iff (rst_i)
    last_w |-> (push_ok_w ^ drop_w));

endmodule

// File: tb/tb_fir_decim_accum.sv
// Directed bench for fir_decim_accum: SHIFT=2 and SHIFT=0 instances, DECIM=4.
module tb_fir_decim_accum;

`ifdef FIR_DECIM_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v2, r2, fc2, ov2, ovr2, st2;
  logic [7:0] d2, od2;
  logic       v0, r0, fc0, ov0, ovr0, st0;
  logic [7:0] d0, od0;

  int checks = 0;
  int errors = 0;

  fir_decim_accum #(.WL(8), .WF(6), .DECIM(4), .SHIFT(2)) u_s2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (v2),
    .in_data_i   (d2),
    .out_valid_o (ov2),
    .out_ready_i (r2),
    .out_data_o  (od2),
    .overrun_o   (ovr2),
    .sat_o       (st2),
    .flag_clr_i  (fc2)
  );

  fir_decim_accum #(.WL(8), .WF(6), .DECIM(4), .SHIFT(0)) u_s0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (v0),
    .in_data_i   (d0),
    .out_valid_o (ov0),
    .out_ready_i (r0),
    .out_data_o  (od0),
    .overrun_o   (ovr0),
    .sat_o       (st0),
    .flag_clr_i  (fc0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed2(input logic [7:0] d, input int n);
    v2 = 1'b1;
    d2 = d;
    repeat (n) step();
    v2 = 1'b0;
  endtask

  task automatic feed0(input logic [7:0] d, input int n);
    v0 = 1'b1;
    d0 = d;
    repeat (n) step();
    v0 = 1'b0;
  endtask

  task automatic pop2();
    r2 = 1'b1;
    step();
    r2 = 1'b0;
  endtask

  task automatic pop0();
    r0 = 1'b1;
    step();
    r0 = 1'b0;
  endtask

  initial begin
    {v2, r2, fc2, v0, r0, fc0} = '0;
    d2  = '0;
    d0  = '0;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_valid", ov2, 1'b0);
    chk("rst_data", od2, 8'h00);
    chk("rst_overrun", ovr2, 1'b0);
    chk("rst_sat", st2, 1'b0);
    chk("rst_data_s0", od0, 8'h00);
    rst = 1'b0;
    step();

    // Four equal samples average back to themselves.
    feed2(8'h10, 3);
    chk("avg_early", ov2, 1'b0);
    feed2(8'h10, 1);
    chk("avg_valid", ov2, 1'b1);
    chk("avg_data", od2, 8'h10);
    chk("avg_sat", st2, 1'b0);
    pop2();
    chk("avg_popped", ov2, 1'b0);

    // Sum 3 >>> 2, then sum -1 >>> 2.
    feed2(8'h01, 3);
    feed2(8'h00, 1);
    chk("small_pos", od2, Rnd ? 8'h01 : 8'h00);
    pop2();
    feed2(8'hFF, 1);
    feed2(8'h00, 3);
    chk("small_neg", od2, Rnd ? 8'h00 : 8'hFF);
    pop2();

    // Unity-shift instance saturates both ways; event beats a coincident clear.
    feed0(8'h40, 4);
    chk("satp_data", od0, 8'h7F);
    chk("satp_flag", st0, 1'b1);
    pop0();
    fc0 = 1'b1;
    step();
    fc0 = 1'b0;
    chk("sat_clr", st0, 1'b0);
    feed0(8'h80, 4);
    chk("satn_data", od0, 8'h80);
    chk("satn_flag", st0, 1'b1);
    pop0();
    fc0 = 1'b1;
    step();
    feed0(8'h80, 3);
    feed0(8'h80, 1);
    fc0 = 1'b0;
    chk("sat_clr_race", st0, 1'b1);
    pop0();
    chk("s2_sat_quiet", st2, 1'b0);

    // Backpressure: two results buffered, third dropped.
    feed2(8'h08, 8);
    chk("ovr_two_ok", ovr2, 1'b0);
    feed2(8'h08, 4);
    chk("ovr_flag", ovr2, 1'b1);
    chk("ovr_head", od2, 8'h08);
    r2 = 1'b1;
    step();
    chk("ovr_pop1", ov2, 1'b1);
    chk("ovr_pop1_data", od2, 8'h08);
    step();
    r2 = 1'b0;
    chk("ovr_pop2", ov2, 1'b0);
    fc2 = 1'b1;
    step();
    fc2 = 1'b0;
    chk("ovr_clr", ovr2, 1'b0);

    // FIFO order, and a push while full that coincides with a pop.
    feed2(8'h10, 4);
    feed2(8'h04, 4);
    feed2(8'h0C, 3);
    r2 = 1'b1;
    feed2(8'h0C, 1);
    r2 = 1'b0;
    chk("full_pushpop_ovr", ovr2, 1'b0);
    chk("order_head", od2, 8'h04);
    pop2();
    chk("order_next", od2, 8'h0C);
    pop2();
    chk("order_empty", ov2, 1'b0);
    chk("order_stable", od2, 8'h0C);

    // Reset mid-accumulation discards the partial sum.
    feed2(8'h20, 2);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("midrst_data", od2, 8'h00);
    feed2(8'h04, 3);
    chk("midrst_early", ov2, 1'b0);
    feed2(8'h04, 1);
    chk("midrst_valid", ov2, 1'b1);
    chk("midrst_data2", od2, 8'h04);
    pop2();

    // Gaps in in_valid do not advance the count.
    d2 = 8'h0C;
    for (int i = 0; i < 7; i++) begin
      v2 = (i % 2 == 0);
      step();
      if (i < 6) chk("gap_early", ov2, 1'b0);
    end
    v2 = 1'b0;
    chk("gap_valid", ov2, 1'b1);
    chk("gap_data", od2, 8'h0C);
    step();
    chk("gap_hold", od2, 8'h0C);
    pop2();
    chk("gap_popped", ov2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_accum.md
Name: fir_decim_accum

Overview:
- Downstream neighbour of the 3-tap Q2.6 FIR stage.
- Consumes one filtered sample per qualified clock and accumulates DECIM consecutive samples.
- Emits one scaled, rounded and saturated Q2.6 result per DECIM inputs.
- Results pass through a 2-entry valid/ready output buffer. The FIR has no backpressure, so overflow of the buffer is flagged rather than stalled.

Parameters:
- WL, 8, sample word length (signed, two's complement).
- WF, 6, fractional bits; input and output are both Q(WL-WF).WF.
- DECIM, 4, decimation factor; power of two, 2..64.
- SHIFT, log2(DECIM), arithmetic right shift applied to the sum; 0..log2(DECIM). SHIFT < log2(DECIM) gives gain 2^(log2(DECIM)-SHIFT).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in_data (the FIR enable/strobe).
- in_data  in  WL  signed filtered sample from the FIR stage.
- out_valid  out  1  output buffer non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WL  signed decimated result; head of the buffer.
- overrun  out  1  sticky: a result was dropped because the buffer was full.
- sat  out  1  sticky: a result was clipped to the WL range.
- flag_clr  in  1  synchronous clear of overrun and sat.

Behaviour:
- Reset (async, any time, including mid-accumulation):
  - acc=0, cnt=0, buffer emptied.
  - out_valid=0, out_data=0, overrun=0, sat=0.
  - A partial accumulation is discarded.
- Accumulator:
  - Signed, WL+log2(DECIM) bits, so no internal overflow.
  - in_valid=0 leaves acc and cnt unchanged; gaps are allowed.
- Accepted samples (in_valid=1):
  - If cnt<DECIM-1: acc+=sext(in_data), cnt+=1.
  - If cnt==DECIM-1: sum=acc+sext(in_data) forms the result combinationally; acc<=0, cnt<=0 on the same edge.
- Scaling: res = sum >>> SHIFT (arithmetic, i.e. floor).
- Saturation:
  - res > 2^(WL-1)-1 → 0x7F; res < -2^(WL-1) → 0x80 (WL=8 values).
  - Either case sets sat on that edge.
- Push: the scaled/saturated result is pushed into the buffer at the same edge the DECIM-th sample is accepted.
- Latency: out_valid rises the cycle after that edge. Buffer empty → 1 cycle from final sample to out_valid.
- Output buffer:
  - 2-entry FIFO, registered out_valid/out_data, FIFO-ordered.
  - Pop when out_valid && out_ready.
  - Push while full: accepted only if a pop occurs in the same cycle. Otherwise the new result is dropped, buffer contents are unchanged, and overrun<=1.
  - Push and pop on empty+1: occupancy stays 1, head advances.
- out_data holds its value while out_valid=1 && out_ready=0.
- out_data is don't-care-but-stable (last value) when out_valid=0.
- flag_clr in the same cycle as a new sat/overrun event: the event wins, flag stays 1.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined and SHIFT>0: round half up, res = (sum + 2^(SHIFT-1)) >>> SHIFT, saturation applied after rounding.
- Undefined: truncation (floor) as above.
- SHIFT=0: identical in both builds.

Decomposition:
- Shared package fir_pkg holds:
  - the Q2.6 constants: WL=8, WF=6, SAT_MAX=8'h7F, SAT_MIN=8'h80;
  - a saturate-to-WL function;
  - the clog2 helper.
- One sub-module, fir_out_fifo2: 2-entry valid/ready buffer with push, push_ok, pop, and an overrun pulse.

Test Plan:
- DECIM=4, SHIFT=2, in_valid=1 continuously, in_data=0x10 ×4 → one result 0x10; out_valid rises 1 cycle after the 4th sample; sat=0.
- Same config, inputs 1,1,1,0 → out 0x00 truncated; 0x01 with FIR_DECIM_ROUND_EN. Inputs -1,0,0,0 → 0xFF truncated; 0x00 rounded.
- DECIM=4, SHIFT=0:
  - 0x40 ×4 (sum 256) → 0x7F, sat=1.
  - After flag_clr, 0x80 ×4 (sum -512) → 0x80, sat=1.
- out_ready=0 held, 12 samples at 0x08 → 2 results buffered (0x08, 0x08), 3rd dropped, overrun=1. Then out_ready=1 → exactly two pops, then out_valid=0.
- Assert RST after 2 of 4 samples (0x20,0x20), release, then send 0x04 ×4 → single result 0x04; the partial sum does not leak.
- in_valid toggled 1,0,1,0… with data 0x0C → result 0x0C after the 4th valid sample; idle cycles do not advance cnt.
